multiplexador_arbitrado: RTL and testbench

MULTIPLEXADOR_ARBITRADO -- requirements
Module: multiplexador_arbitrado

---
 rtl/multiplexador_arbitrado.sv | 127 ++++++++++++
 tb/tb_multiplexador_arbitrado.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multiplexador_arbitrado.sv
// multiplexador_arbitrado
// Selects one of CANAIS request channels and moves its word into a single
// registered output slot with a valid/ready handshake. The grant is made
// either by an external channel select (MODO=0) or by a round-robin
// arbiter (MODO=1). The slot reloads in the same cycle it drains, so a
// steady stream runs at one word per clock with one cycle of latency.

module multiplexador_arbitrado #(
    parameter int LARGURA = 16,
    parameter int CANAIS  = 8,
    parameter int MODO    = 0,
    localparam int SEL_W  = (CANAIS > 1) ? $clog2(CANAIS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CANAIS*LARGURA-1:0] entradas,
    input  logic [CANAIS-1:0]         pedido,
    input  logic [SEL_W-1:0]          controle,
    output logic [CANAIS-1:0]         concedido,
    output logic [LARGURA-1:0]        saida,
    output logic                      saida_valida,
    input  logic                      saida_pronta,
    output logic [SEL_W-1:0]          canal_atual
);

    // Constant one at channel-vector width, used to isolate the lowest set bit.
    localparam logic [CANAIS-1:0] L_UM = {{(CANAIS-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [LARGURA-1:0] r_saida;
    logic               r_valida;
    logic [SEL_W-1:0]   r_canal;
    logic [SEL_W-1:0]   r_ponteiro;

    // ------------------------------------------------------------------
    // Combinational grant path
    // ------------------------------------------------------------------
    logic               w_livre;
    logic [CANAIS-1:0]  w_sel_ctl;
    logic [CANAIS-1:0]  w_req_alto;
    logic [CANAIS-1:0]  w_pri_alto;
    logic [CANAIS-1:0]  w_pri_todos;
    logic [CANAIS-1:0]  w_sel_rr;
    logic [CANAIS-1:0]  w_concessao;
    logic               w_tem_concessao;
    logic [SEL_W-1:0]   w_idx;
    logic [SEL_W-1:0]   w_ptr_prox;
    logic [LARGURA-1:0] w_dado_sel;

    // The slot can take a new word when it is empty or being drained now.
    assign w_livre = !r_valida || saida_pronta;

    // Per-channel terms for both selection schemes.
    //  - w_sel_ctl: channel named by controle, only if it is requesting. A
    //    controle value beyond the last channel matches no bit, so it
    //    naturally produces no grant.
    //  - w_req_alto: requests at or above the round-robin pointer; these
    //    win over the wrapped-around requests below the pointer.
    generate
        for (genvar gi = 0; gi < CANAIS; gi++) begin : g_canal
            assign w_sel_ctl[gi]  = pedido[gi] && (controle == SEL_W'(gi));
            assign w_req_alto[gi] = pedido[gi] && (SEL_W'(gi) >= r_ponteiro);
        end
    endgenerate

    // Round-robin: lowest request at/above the pointer, otherwise the lowest
    // request overall (the wrap from CANAIS-1 back to 0).
    assign w_pri_alto  = w_req_alto & (~w_req_alto + L_UM);
    assign w_pri_todos = pedido & (~pedido + L_UM);
    assign w_sel_rr    = (|w_req_alto) ? w_pri_alto : w_pri_todos;

    // Grant only when the slot is free and not in reset.
    assign w_concessao     = (reset || !w_livre) ? '0
                           : ((MODO == 1) ? w_sel_rr : w_sel_ctl);
    assign w_tem_concessao = |w_concessao;
    assign concedido       = w_concessao;

    // Encode the one-hot grant into an index and pick that channel's data.
    always_comb begin
        w_idx      = '0;
        w_dado_sel = '0;
        for (int i = 0; i < CANAIS; i++) begin
            if (w_concessao[i]) begin
                w_idx      = SEL_W'(i);
                w_dado_sel = entradas[i*LARGURA +: LARGURA];
            end
        end
    end

    // Pointer moves to the channel after the one just granted, wrapping.
    assign w_ptr_prox = (w_idx == SEL_W'(CANAIS - 1)) ? '0 : (w_idx + SEL_W'(1));

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Output slot: load on grant, empty on drain without reload, else hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_saida  <= '0;
            r_canal  <= '0;
            r_valida <= 1'b0;
        end else if (w_tem_concessao) begin
            r_saida  <= w_dado_sel;
            r_canal  <= w_idx;
            r_valida <= 1'b1;
        end else if (w_livre) begin
            r_valida <= 1'b0;
        end
    end

    // Round-robin pointer: advances only on a grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ponteiro <= '0;
        end else if (w_tem_concessao) begin
            r_ponteiro <= w_ptr_prox;
        end
    end

    assign saida        = r_saida;
    assign saida_valida = r_valida;
    assign canal_atual  = r_canal;

endmodule

// File: tb/tb_multiplexador_arbitrado.sv
// Bench for multiplexador_arbitrado. Three instances run side by side:
//   0: MODO=0, CANAIS=8   1: MODO=1, CANAIS=8   2: MODO=0, CANAIS=6
// A reference model computes the expected grant each cycle and pushes the
// expected delivered word into a per-instance queue; a monitor pops and
// compares each word as it is handed downstream.

module tb_multiplexador_arbitrado;

    localparam int ND = 3;

    logic         clock;
    logic         rst;
    logic [127:0] ent_a    [ND];
    logic [7:0]   ped_a    [ND];
    logic [2:0]   ctl_a    [ND];
    logic         pronta_a [ND];
    logic [7:0]   conc_a   [ND];
    logic [15:0]  saida_a  [ND];
    logic         val_a    [ND];
    logic [2:0]   canal_a  [ND];

    int total = 0;
    int bad   = 0;

    // Reference model state (after the most recent edge).
    bit          m_val   [ND];
    logic [15:0] m_saida [ND];
    int          m_canal [ND];
    int          m_ptr   [ND];
    logic [18:0] sbq     [ND][$];
    logic [7:0]  last_conc [ND];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    generate
        for (genvar gi = 0; gi < ND; gi++) begin : g_dut
            localparam int CN = (gi == 2) ? 6 : 8;
            localparam int MD = (gi == 1) ? 1 : 0;
            logic [CN-1:0] w_conc;
            logic [15:0]   w_saida;
            logic          w_val;
            logic [2:0]    w_canal;
            multiplexador_arbitrado #(.LARGURA(16), .CANAIS(CN), .MODO(MD)) u_dut (
                .clock        (clock),
                .reset        (rst),
                .entradas     (ent_a[gi][CN*16-1:0]),
                .pedido       (ped_a[gi][CN-1:0]),
                .controle     (ctl_a[gi]),
                .concedido    (w_conc),
                .saida        (w_saida),
                .saida_valida (w_val),
                .saida_pronta (pronta_a[gi]),
                .canal_atual  (w_canal)
            );
            assign conc_a[gi]  = 8'(w_conc);
            assign saida_a[gi] = w_saida;
            assign val_a[gi]   = w_val;
            assign canal_a[gi] = w_canal;
        end
    endgenerate

    function automatic int cn(input int d);
        return (d == 2) ? 6 : 8;
    endfunction

    function automatic int md(input int d);
        return (d == 1) ? 1 : 0;
    endfunction

    // Expected granted channel, or -1 for none.
    function automatic int model_grant(input int mode, input int n, input int ptr,
                                       input logic [7:0] ped, input int ctl, input bit livre);
        if (!livre) return -1;
        if (mode == 0) begin
            if (ctl < n && ped[ctl]) return ctl;
            return -1;
        end
        for (int j = 0; j < n; j++) begin
            int c;
            c = (ptr + j) % n;
            if (ped[c]) return c;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock cycle: inputs were applied just after the previous edge.
    task automatic cycle();
        int          k;
        bit          livre;
        logic [7:0]  eg;
        logic [15:0] dado;
        #1;
        for (int d = 0; d < ND; d++) begin
            livre = !m_val[d] || pronta_a[d];
            k = rst ? -1 : model_grant(md(d), cn(d), m_ptr[d], ped_a[d], int'(ctl_a[d]), livre);
            eg = (k >= 0) ? (8'd1 << k) : 8'd0;
            last_conc[d] = conc_a[d];
            chk($sformatf("concedido d%0d", d), {24'd0, conc_a[d]}, {24'd0, eg});
            if (rst) begin
                m_val[d] = 0; m_saida[d] = '0; m_canal[d] = 0; m_ptr[d] = 0;
                sbq[d].delete();
            end else if (k >= 0) begin
                dado = ent_a[d][k*16 +: 16];
                m_val[d] = 1; m_saida[d] = dado; m_canal[d] = k;
                m_ptr[d] = (k + 1) % cn(d);
                sbq[d].push_back({3'(k), dado});
            end else if (livre) begin
                m_val[d] = 0;
            end
        end
        @(posedge clock);
        #1;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("saida_valida d%0d", d), {31'd0, val_a[d]}, {31'd0, m_val[d]});
            chk($sformatf("saida d%0d", d), {16'd0, saida_a[d]}, {16'd0, m_saida[d]});
            chk($sformatf("canal_atual d%0d", d), {29'd0, canal_a[d]}, 32'(m_canal[d]));
        end
    endtask

    task automatic set_all(input logic [7:0] ped, input logic [2:0] ctl, input logic pr);
        for (int d = 0; d < ND; d++) begin
            ped_a[d] = ped; ctl_a[d] = ctl; pronta_a[d] = pr;
            ent_a[d] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // Monitor: mid-cycle, any word being accepted downstream is compared.
    initial begin
        logic [18:0] exp_w;
        forever begin
            @(negedge clock);
            if (!rst) begin
                for (int d = 0; d < ND; d++) begin
                    if (val_a[d] === 1'b1 && pronta_a[d] === 1'b1) begin
                        if (sbq[d].size() == 0) begin
                            chk($sformatf("unexpected word d%0d", d), {13'd0, canal_a[d], saida_a[d]}, 32'hFFFF_FFFF);
                        end else begin
                            exp_w = sbq[d].pop_front();
                            $display("deliver d%0d canal=%0d dado=%h", d, canal_a[d], saida_a[d]);
                            chk($sformatf("delivered d%0d", d), {13'd0, canal_a[d], saida_a[d]}, {13'd0, exp_w});
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        set_all(8'h00, 3'd0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        cycle();
        cycle();
        rst = 1'b0;

        // Control-selected load of channel 3; round-robin burst; invalid select.
        set_all(8'hFF, 3'd3, 1'b1);
        ent_a[0][3*16 +: 16] = 16'hA5A5;
        ped_a[1] = 8'b1000_0101;
        ctl_a[2] = 3'd2;
        cycle();
        chk("req031 concedido", {24'd0, last_conc[0]}, 32'h08);
        chk("req031 saida", {16'd0, saida_a[0]}, 32'hA5A5);
        chk("req031 canal", {29'd0, canal_a[0]}, 32'd3);
        chk("rr grant 1", {24'd0, last_conc[1]}, 32'h01);
        ctl_a[2] = 3'd7;
        cycle();
        chk("rr grant 2", {24'd0, last_conc[1]}, 32'h04);
        chk("sel beyond range drains", {31'd0, val_a[2]}, 32'd0);
        cycle();
        chk("rr grant 3", {24'd0, last_conc[1]}, 32'h80);
        cycle();
        chk("rr grant 4", {24'd0, last_conc[1]}, 32'h01);

        // Backpressure: three stalled cycles, then release.
        set_all(8'hFF, 3'd5, 1'b0);
        repeat (3) begin
            cycle();
            chk("stall no grant", {24'd0, last_conc[1]}, 32'h00);
        end
        pronta_a[1] = 1'b1;
        cycle();
        chk("release grant", {24'd0, last_conc[1]}, 32'h02);

        // Reset while holding a stalled word.
        set_all(8'hFF, 3'd1, 1'b0);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("reset saida", {16'd0, saida_a[1]}, 32'd0);
        set_all(8'hFF, 3'd1, 1'b1);
        cycle();
        chk("rr restart at 0", {24'd0, last_conc[1]}, 32'h01);

        // Idle drain: word leaves, data stays.
        set_all(8'h00, 3'd1, 1'b1);
        cycle();
        chk("idle drain valida", {31'd0, val_a[1]}, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            for (int d = 0; d < ND; d++) begin
                ent_a[d]    = {$urandom, $urandom, $urandom, $urandom};
                ped_a[d]    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                ctl_a[d]    = 3'($urandom_range(0, 7));
                pronta_a[d] = ($urandom_range(0, 3) != 0);
            end
            rst = ($urandom_range(0, 49) == 0);
            cycle();
        end
        rst = 1'b0;

        // Drain everything and confirm nothing was left undelivered.
        set_all(8'h00, 3'd0, 1'b1);
        cycle();
        cycle();
        for (int d = 0; d < ND; d++)
            chk($sformatf("queue empty d%0d", d), 32'(sbq[d].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
